// File: rtl/bell_pkg.sv
// Shared definitions for the bell stage: note codes, tune entry layout and tune ROM contents.
package bell_pkg;

   localparam logic [2:0] NOTE_REST = 3'd0;
   localparam logic [2:0] NOTE_DO   = 3'd1;
   localparam logic [2:0] NOTE_RE   = 3'd2;
   localparam logic [2:0] NOTE_MI   = 3'd3;
   localparam logic [2:0] NOTE_FA   = 3'd4;
   localparam logic [2:0] NOTE_SOL  = 3'd5;
   localparam logic [2:0] NOTE_LA   = 3'd6;
   localparam logic [2:0] NOTE_TI   = 3'd7;

   localparam int TUNE_LEN = 16;

   typedef struct packed {
      logic [2:0] note;
      logic [3:0] beats;
   } tune_entry_t;

   // beats == 0 marks the end of a tune; unlisted entries read as terminators.
   function automatic tune_entry_t tune_rom_read(input logic [1:0] tune, input logic [3:0] idx);
      tune_entry_t e;
      e = '{note: NOTE_REST, beats: 4'd0};
      case (tune)
         2'd0: begin
            if (idx < 4'd7) e = '{note: 3'(idx) + 3'd1, beats: 4'd1};
         end
         2'd1: begin
            case (idx)
               4'd0:    e = '{note: NOTE_SOL,  beats: 4'd2};
               4'd1:    e = '{note: NOTE_REST, beats: 4'd1};
               4'd2:    e = '{note: NOTE_MI,   beats: 4'd4};
               default: e = '{note: NOTE_REST, beats: 4'd0};
            endcase
         end
         2'd2: begin
            e = '{note: NOTE_REST, beats: 4'd0};
         end
         default: begin
            e = '{note: 3'(idx % 4'd7) + 3'd1, beats: 4'd1};
         end
      endcase
      return e;
   endfunction

endpackage

// File: rtl/bell_tune_rom.sv
// Tune ROM with a registered one-cycle read; addr = {tune, idx}.
module bell_tune_rom
   import bell_pkg::*;
(
   input  logic        clk,
   input  logic [5:0]  addr,
   output tune_entry_t entry
);

   // Registered lookup so the ROM maps onto a synchronous memory.
   always_ff @(posedge clk) begin
      entry <= tune_rom_read(addr[5:4], addr[3:0]);
   end

endmodule

// File: rtl/bell_tune_player.sv
// Note sequencer: plays one of four stored tunes on a start pulse and drives bell_code.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; outputs quiet
// S_LOAD   | ROM entry for (tune, idx) arriving; decide note or finish
// S_PLAY   | holding the note; down-counter to the articulation gap
// S_GAP    | silence closing the entry; down-counter to next entry
// S_FINISH | one-cycle done pulse, busy released
module bell_tune_player
   import bell_pkg::*;
#(
   parameter int unsigned BEAT_CYCLES = 6_250_000,
   parameter int unsigned GAP_CYCLES  = 500_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic [1:0] tune_sel,
   output logic [2:0] bell_code,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_PLAY,
      S_GAP,
      S_FINISH
   } state_t;

   localparam logic [26:0] BEAT_W   = 27'(BEAT_CYCLES);
   localparam logic [26:0] GAP_W    = 27'(GAP_CYCLES);
   localparam logic [3:0]  IDX_LAST = 4'(TUNE_LEN - 1);

   state_t      state;
   logic [1:0]  tune_q;
   logic [3:0]  idx;
   logic [26:0] cnt;
   logic        load_wait;
   logic [3:0]  rom_idx;
   logic [26:0] play_len;
   tune_entry_t rom_entry;

   // Look ahead to the next index on the last GAP cycle so the entry is ready in LOAD.
   assign rom_idx  = (state == S_GAP && cnt == '0) ? idx + 4'd1 : idx;
   assign play_len = 27'(rom_entry.beats) * BEAT_W - GAP_W - 27'd1;

   bell_tune_rom u_rom (
      .clk   (clk),
      .addr  ({tune_q, rom_idx}),
      .entry (rom_entry)
   );

   // Sequencer FSM with registered outputs; stop aborts from any active state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         tune_q    <= '0;
         idx       <= '0;
         cnt       <= '0;
         load_wait <= 1'b0;
         bell_code <= NOTE_REST;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (stop && state != S_IDLE) begin
            state     <= S_IDLE;
            cnt       <= '0;
            load_wait <= 1'b0;
            bell_code <= NOTE_REST;
            busy      <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start && !stop) begin
                     tune_q    <= tune_sel;
                     idx       <= '0;
                     busy      <= 1'b1;
                     load_wait <= 1'b1;
                     state     <= S_LOAD;
                  end
               end
               S_LOAD: begin
                  // After a start the tune register was just written, so the ROM needs one more cycle.
                  if (load_wait) begin
                     load_wait <= 1'b0;
                  end else if (rom_entry.beats == 4'd0) begin
                     state <= S_FINISH;
                  end else begin
                     bell_code <= rom_entry.note;
                     cnt       <= play_len;
                     state     <= S_PLAY;
                  end
               end
               S_PLAY: begin
                  if (cnt == '0) begin
                     bell_code <= NOTE_REST;
                     cnt       <= GAP_W - 27'd1;
                     state     <= S_GAP;
                  end else begin
                     cnt <= cnt - 27'd1;
                  end
               end
               S_GAP: begin
                  if (cnt == '0) begin
                     if (idx == IDX_LAST) begin
                        state <= S_FINISH;
                     end else begin
                        idx   <= idx + 4'd1;
                        state <= S_LOAD;
                     end
                  end else begin
                     cnt <= cnt - 27'd1;
                  end
               end
               S_FINISH: begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bell_tune_player.sv
// Directed bench for bell_tune_player with a per-cycle expected-output scoreboard.
module tb_bell_tune_player;

   localparam int BEAT = 10;
   localparam int GAP  = 2;

   logic       clk;
   logic       rst;
   logic       start;
   logic       stop;
   logic [1:0] tune_sel;
   logic [2:0] bell_code;
   logic       busy;
   logic       done;

   logic [4:0] exp_q[$];
   int         checks;
   int         errors;
   int         cyc;
   string      tag;

   bell_tune_player #(
      .BEAT_CYCLES (BEAT),
      .GAP_CYCLES  (GAP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .tune_sel  (tune_sel),
      .bell_code (bell_code),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference tune table.
   task automatic get_entry(input int t, input int i, output int n, output int b);
      n = 0;
      b = 0;
      if (t == 0) begin
         if (i < 7) begin n = i + 1; b = 1; end
      end else if (t == 1) begin
         if (i == 0) begin n = 5; b = 2; end
         if (i == 1) begin n = 0; b = 1; end
         if (i == 2) begin n = 3; b = 4; end
      end else if (t == 3) begin
         n = (i % 7) + 1;
         b = 1;
      end
   endtask

   task automatic push_exp(input logic [2:0] c, input logic bz, input logic d, input int n);
      for (int j = 0; j < n; j++) exp_q.push_back({c, bz, d});
   endtask

   // Expected outputs after each edge, starting with the edge that accepts start.
   task automatic push_tune(input int t);
      int n;
      int b;
      push_exp(3'd0, 1'b1, 1'b0, 2);
      for (int i = 0; i < 16; i++) begin
         get_entry(t, i, n, b);
         if (b == 0) begin
            push_exp(3'd0, 1'b1, 1'b0, 1);
            break;
         end
         push_exp(3'(n), 1'b1, 1'b0, b * BEAT - GAP);
         push_exp(3'd0, 1'b1, 1'b0, 3);
      end
      push_exp(3'd0, 1'b0, 1'b1, 1);
      push_exp(3'd0, 1'b0, 1'b0, 2);
   endtask

   task automatic cycle();
      logic [4:0] e;
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 5'b0;
      checks++;
      assert ({bell_code, busy, done} === e) else begin
         errors++;
         $error("FAIL %s cycle %0d: got code=%0d busy=%0b done=%0b, expected code=%0d busy=%0b done=%0b",
                tag, cyc, bell_code, busy, done, e[4:2], e[1], e[0]);
      end
   endtask

   task automatic run(input int n);
      for (int j = 0; j < n; j++) cycle();
   endtask

   task automatic drain();
      int budget;
      budget = 400;
      while (exp_q.size() > 0 && budget > 0) begin
         cycle();
         budget--;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s drain: %0d expectations left, expected 0", tag, exp_q.size());
      end
   endtask

   task automatic play(input logic [1:0] t);
      tune_sel = t;
      start    = 1'b1;
      push_tune(int'(t));
      cycle();
      start    = 1'b0;
      tune_sel = ~t;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      cyc      = 0;
      rst      = 1'b1;
      start    = 1'b0;
      stop     = 1'b0;
      tune_sel = 2'd0;

      tag = "reset";
      push_exp(3'd0, 1'b0, 1'b0, 2);
      drain();
      rst = 1'b0;
      push_exp(3'd0, 1'b0, 1'b0, 2);
      drain();

      tag = "t1_tune0";
      play(2'd0);
      drain();

      tag = "t2_tune1";
      play(2'd1);
      drain();

      tag = "t3_empty";
      play(2'd2);
      drain();

      tag = "t4_tune3_wrap";
      play(2'd3);
      drain();

      tag = "t5_stop";
      play(2'd0);
      run(26);
      stop = 1'b1;
      exp_q.delete();
      push_exp(3'd0, 1'b0, 1'b0, 4);
      cycle();
      stop = 1'b0;
      drain();
      tag = "t5_restart";
      play(2'd0);
      drain();

      tag = "t6_start_busy";
      play(2'd1);
      run(20);
      tune_sel = 2'd2;
      start    = 1'b1;
      cycle();
      start    = 1'b0;
      drain();

      tag = "t6_start_stop";
      tune_sel = 2'd0;
      start    = 1'b1;
      stop     = 1'b1;
      push_exp(3'd0, 1'b0, 1'b0, 4);
      cycle();
      start = 1'b0;
      stop  = 1'b0;
      drain();

      tag = "t6_rst_mid_play";
      play(2'd1);
      run(5);
      rst = 1'b1;
      exp_q.delete();
      push_exp(3'd0, 1'b0, 1'b0, 3);
      cycle();
      rst = 1'b0;
      drain();

      tag = "t6_after_rst";
      play(2'd2);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
